// File: rtl/conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// conv_job_arbiter: two-client round-robin front end for the convolution engine.
// Stages one job, replays it as a gap-free burst and routes results back.
// Revision: 1.0
// ============================================================================
module conv_job_arbiter #(
    parameter int N_FILT = 10,
    parameter int N_IMG  = 64,
    parameter int N_OUT  = 16,
    parameter int DW     = 4,
    parameter int OW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_i,
    output logic [1:0]    gnt_o,
    input  logic [1:0]    cl_valid_i,
    input  logic [DW-1:0] cl_data0_i,
    input  logic [DW-1:0] cl_data1_i,
    output logic          filter_valid_o,
    output logic          image_valid_o,
    output logic [DW-1:0] in_data_o,
    input  logic          eng_out_valid_i,
    input  logic [OW-1:0] eng_out_data_i,
    output logic [1:0]    res_valid_o,
    output logic [OW-1:0] res_data_o,
    output logic          res_last_o,
    output logic          busy_o
);

    localparam int            N_JOB    = N_FILT + N_IMG;
    localparam logic [6:0]    LAST_PTR = 7'(N_JOB - 1);
    localparam logic [6:0]    FILT_END = 7'(N_FILT);
    localparam logic [4:0]    LAST_RES = 5'(N_OUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] FEED = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [1:0]    gnt_q,       gnt_d;
    logic          rr_q,        rr_d;
    logic          client_q,    client_d;
    logic [6:0]    wr_ptr_q,    wr_ptr_d;
    logic [6:0]    rd_ptr_q,    rd_ptr_d;
    logic          eng_busy_q,  eng_busy_d;
    logic          owner_q,     owner_d;
    logic [4:0]    res_cnt_q,   res_cnt_d;
    logic          filt_q,      filt_d;
    logic          img_q,       img_d;
    logic [DW-1:0] in_data_q,   in_data_d;
    logic [1:0]    res_valid_q, res_valid_d;
    logic [OW-1:0] res_data_q,  res_data_d;
    logic          res_last_q,  res_last_d;
    logic          busy_q,      busy_d;

    logic [DW-1:0] job_buf [N_JOB];

    logic          wr_en;
    logic [DW-1:0] wr_data;

    // Only the granted client's strobe and nibble reach the staging buffer.
    assign wr_en   = (state_q == LOAD) && gnt_q[client_q] && cl_valid_i[client_q];
    assign wr_data = client_q ? cl_data1_i : cl_data0_i;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        client_d    = client_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        eng_busy_d  = eng_busy_q;
        owner_d     = owner_q;
        res_cnt_d   = res_cnt_q;
        filt_d      = 1'b0;
        img_d       = 1'b0;
        in_data_d   = '0;
        res_valid_d = 2'b00;
        res_data_d  = res_data_q;
        res_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    client_d = req_i[rr_q] ? rr_q : ~rr_q;
                    gnt_d    = client_d ? 2'b10 : 2'b01;
                    rr_d     = ~client_d;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (wr_en) begin
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        gnt_d    = 2'b00;
                        state_d  = eng_busy_q ? WAIT : FEED;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 7'd1;
                    end
                end
            end
            WAIT: begin
                if (!eng_busy_q) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                in_data_d = job_buf[rd_ptr_q];
                filt_d    = (rd_ptr_q < FILT_END);
                img_d     = (rd_ptr_q >= FILT_END);
                if (rd_ptr_q == '0) begin
                    eng_busy_d = 1'b1;
                    owner_d    = client_q;
                    res_cnt_d  = '0;
                end
                if (rd_ptr_q == LAST_PTR) begin
                    rd_ptr_d = '0;
                    state_d  = IDLE;
                end else begin
                    rd_ptr_d = rd_ptr_q + 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results are counted, not timed; strobes outside a job are dropped.
        if (eng_busy_q && eng_out_valid_i) begin
            res_valid_d[owner_q] = 1'b1;
            res_data_d           = eng_out_data_i;
            if (res_cnt_q == LAST_RES) begin
                res_last_d = 1'b1;
                eng_busy_d = 1'b0;
                res_cnt_d  = '0;
            end else begin
                res_cnt_d = res_cnt_q + 5'd1;
            end
        end

        busy_d = (state_d != IDLE) || eng_busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            rr_q        <= 1'b0;
            client_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            eng_busy_q  <= 1'b0;
            owner_q     <= 1'b0;
            res_cnt_q   <= '0;
            filt_q      <= 1'b0;
            img_q       <= 1'b0;
            in_data_q   <= '0;
            res_valid_q <= 2'b00;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            client_q    <= client_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            eng_busy_q  <= eng_busy_d;
            owner_q     <= owner_d;
            res_cnt_q   <= res_cnt_d;
            filt_q      <= filt_d;
            img_q       <= img_d;
            in_data_q   <= in_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
        end
    end

    // Buffer contents need no reset: every entry is rewritten before replay.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            job_buf[wr_ptr_q] <= wr_data;
        end
    end

    assign gnt_o          = gnt_q;
    assign filter_valid_o = filt_q;
    assign image_valid_o  = img_q;
    assign in_data_o      = in_data_q;
    assign res_valid_o    = res_valid_q;
    assign res_data_o     = res_data_q;
    assign res_last_o     = res_last_q;
    assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_conv_job_arbiter: directed bench with an engine model and scoreboards.
// Revision: 1.0
// ============================================================================
module tb_conv_job_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  cl_valid;
    logic [3:0]  cl_data0;
    logic [3:0]  cl_data1;
    logic        filter_valid;
    logic        image_valid;
    logic [3:0]  in_data;
    logic        eng_out_valid;
    logic [15:0] eng_out_data;
    logic [1:0]  res_valid;
    logic [15:0] res_data;
    logic        res_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [4:0]  feed_q  [$];
    logic [18:0] res_q   [$];
    logic [1:0]  owner_q [$];
    int feeds_seen     = 0;
    int served         = 0;
    int res_lasts_seen = 0;
    int stray_cnt      = 0;
    int eng_lat        = 2;
    int res_gap        = 0;
    bit e_active       = 1'b0;

    conv_job_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req),
        .gnt_o           (gnt),
        .cl_valid_i      (cl_valid),
        .cl_data0_i      (cl_data0),
        .cl_data1_i      (cl_data1),
        .filter_valid_o  (filter_valid),
        .image_valid_o   (image_valid),
        .in_data_o       (in_data),
        .eng_out_valid_i (eng_out_valid),
        .eng_out_data_i  (eng_out_data),
        .res_valid_o     (res_valid),
        .res_data_o      (res_data),
        .res_last_o      (res_last),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {4'b0, gnt, filter_valid, image_valid, in_data, res_valid, res_data, res_last, busy};
    endfunction

    function automatic logic [3:0] nib(input int i, input int salt);
        if (i < 10) begin
            if (salt == 0) return (i == 0 || i == 5) ? 4'd1 : 4'd0;
            return 4'(i * 3 + salt);
        end
        return 4'(i - 10 + salt);
    endfunction

    function automatic logic [15:0] mk_res(input int job, input int k);
        logic [15:0] r;
        r = 16'(job * 4951 + k * 3857);
        if (k % 2 == 1) r = r ^ 16'h8000;
        return r;
    endfunction

    task automatic drive(input int cl, input bit v, input logic [3:0] d, input bit ov);
        if (cl == 0) begin
            cl_valid = {ov, v};
            cl_data0 = d;
            cl_data1 = ~d;
        end else begin
            cl_valid = {v, ov};
            cl_data1 = d;
            cl_data0 = ~d;
        end
    endtask

    // Replays each fed nibble against the expected job contents.
    task automatic feed_monitor();
        int idx = 0;
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0;
            end else if (filter_valid || image_valid) begin
                if (idx == 0) chk("drained_before_feed", 32'(res_lasts_seen), 32'(feeds_seen));
                if (feed_q.size() == 0) begin
                    chk("feed_extra", 32'(feed_q.size()), 32'd1);
                end else begin
                    e = feed_q.pop_front();
                    chk("feed_nibble", {26'b0, filter_valid, image_valid, in_data},
                        {26'b0, e[4], ~e[4], e[3:0]});
                end
                idx++;
                if (idx == 74) begin
                    idx = 0;
                    feeds_seen++;
                end
            end else if (idx != 0) begin
                chk("feed_gap", 32'(filter_valid | image_valid), 32'd1);
            end
        end
    endtask

    task automatic res_monitor();
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && (res_valid !== 2'b00 || res_last !== 1'b0)) begin
                if (res_q.size() == 0) begin
                    chk("res_extra", {29'b0, res_valid, res_last}, 32'd0);
                end else begin
                    e = res_q.pop_front();
                    chk("result", {13'b0, res_valid, res_data, res_last}, {13'b0, e});
                    if (res_last === 1'b1) res_lasts_seen++;
                end
            end
        end
    endtask

    // Engine model: after a full burst, returns 16 results eng_lat cycles later.
    task automatic engine_model();
        int k = 0;
        int w = 0;
        int job = 0;
        int strays_done = 0;
        logic [1:0] own = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            eng_out_valid = 1'b0;
            if (!rst_n) begin
                e_active = 1'b0;
            end else if (stray_cnt > strays_done) begin
                strays_done++;
                eng_out_valid = 1'b1;
                eng_out_data  = 16'hDEAD;
            end else if (e_active) begin
                if (w > 0) begin
                    w--;
                end else begin
                    eng_out_data  = mk_res(job, k);
                    eng_out_valid = 1'b1;
                    res_q.push_back({own, eng_out_data, (k == 15)});
                    k++;
                    if (k == 16) begin
                        e_active = 1'b0;
                        job++;
                    end else begin
                        w = res_gap;
                    end
                end
            end else if (feeds_seen > served) begin
                served++;
                e_active = 1'b1;
                w = eng_lat;
                k = 0;
                chk("job_owner_avail", 32'(owner_q.size() != 0), 32'd1);
                if (owner_q.size() != 0) own = owner_q.pop_front();
            end
        end
    endtask

    task automatic run_job(input int cl, input bit gap, input bit foreign, input int salt,
                           input int abort_at, input bit chk_t2);
        logic [1:0] exp_g;
        logic [3:0] d;
        exp_g = (cl == 0) ? 2'b01 : 2'b10;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (gnt === exp_g) break;
        end
        chk("gnt_grant", 32'(gnt), 32'(exp_g));
        chk("busy_load", 32'(busy), 32'd1);
        for (int i = 0; i < 74; i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                @(posedge clk);
                #1;
                drive(cl, 1'b0, 4'd0, 1'b0);
                req   = 2'b00;
                rst_n = 1'b0;
                feed_q.delete();
                @(negedge clk);
                chk("mid_reset_outs", outs(), 32'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                chk("post_reset_idle", {29'b0, gnt, busy}, 32'd0);
                return;
            end
            d = nib(i, salt);
            @(posedge clk);
            #1;
            drive(cl, 1'b1, d, foreign & i[0]);
            @(negedge clk);
            chk("gnt_hold", 32'(gnt), 32'(exp_g));
            feed_q.push_back({(i < 10), d});
            if (gap && i < 73) begin
                @(posedge clk);
                #1;
                drive(cl, 1'b0, ~d, foreign);
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        drive(cl, 1'b0, 4'd0, 1'b0);
        owner_q.push_back(exp_g);
        @(negedge clk);
        chk("gnt_drop", 32'(gnt), 32'd0);
        if (chk_t2) begin
            @(posedge clk);
            @(negedge clk);
            chk("first_filter_t2", 32'(filter_valid), 32'd1);
        end
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ok = (feed_q.size() == 0) && (res_q.size() == 0) && (owner_q.size() == 0) &&
                 (served == feeds_seen) && !e_active && (busy === 1'b0);
            if (ok) break;
        end
        chk("drain_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        cl_valid = 2'b00;
        cl_data0 = 4'd0;
        cl_data1 = 4'd0;
        eng_out_valid = 1'b0;
        eng_out_data = 16'd0;
        fork
            feed_monitor();
            res_monitor();
            engine_model();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs(), 32'd0);

        // Client 0, contiguous nibbles, engine idle.
        eng_lat = 2;
        res_gap = 0;
        @(posedge clk);
        #1 req = 2'b01;
        run_job(0, 1'b0, 1'b0, 0, -1, 1'b1);
        req = 2'b00;
        wait_drain();

        // Client 1 with gapped strobes while client 0 pulses its valid.
        res_gap = 1;
        @(posedge clk);
        #1 req = 2'b10;
        run_job(1, 1'b1, 1'b1, 5, -1, 1'b0);
        req = 2'b00;
        wait_drain();

        // Both requesting: three back-to-back jobs with a slow engine.
        eng_lat = 60;
        res_gap = 1;
        @(posedge clk);
        #1 req = 2'b11;
        run_job(0, 1'b0, 1'b0, 3, -1, 1'b0);
        run_job(1, 1'b0, 1'b1, 7, -1, 1'b0);
        run_job(0, 1'b1, 1'b0, 11, -1, 1'b0);
        req = 2'b00;
        wait_drain();

        // Engine strobe with no job outstanding.
        stray_cnt++;
        repeat (4) begin
            @(negedge clk);
            chk("stray_ignored", {29'b0, res_valid, res_last}, 32'd0);
        end

        // Reset in the middle of a load, then a fresh job from client 1.
        eng_lat = 20;
        res_gap = 0;
        @(posedge clk);
        #1 req = 2'b01;
        run_job(0, 1'b0, 1'b0, 2, 40, 1'b0);
        @(posedge clk);
        #1 req = 2'b10;
        run_job(1, 1'b0, 1'b0, 9, -1, 1'b0);
        req = 2'b00;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
